// File: rtl/hazard_pipe_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX hazard control, mult/div busy tracking,
// and imem wait-state handling. Define PIPE_CTRL_STATS_EN to build the stall/flush counters.
module hazard_pipe_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_md,
  input  logic              id_reads_hilo,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              ex_branch_taken,
  input  logic              imem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              md_start,
  output logic              md_busy,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_count
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] IWAIT   = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [7:0] MD_LAT  = 8'(MD_LATENCY);

  logic [1:0] state, state_nxt;
  logic [7:0] md_cnt;
  logic       load_use, hazard;

  always_comb begin
    load_use = ex_memread && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    hazard   = load_use || (md_busy && (id_reads_hilo || id_is_md));
  end

  assign md_busy  = (md_cnt != 8'd0);
  assign md_start = !reset && id_is_md && !md_busy && !ex_branch_taken;

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_nxt   = state;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_nxt   = RUN;
    end else if (ex_branch_taken) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      // A fetch still outstanding at redirect time is wrong-path and must be dropped.
      if (state != RUN) state_nxt = imem_ready ? RUN : DISCARD;
    end else if (state == DISCARD) begin
      if (imem_ready) begin
        ifid_flush = 1'b1;
        state_nxt  = RUN;
      end
    end else if (hazard) begin
      idex_bubble = 1'b1;
    end else if (!imem_ready) begin
      ifid_flush = 1'b1;
      state_nxt  = IWAIT;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      state_nxt  = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             md_cnt <= 8'd0;
    else if (md_start)     md_cnt <= MD_LAT;
    else if (md_cnt != 0)  md_cnt <= md_cnt - 8'd1;
  end

`ifdef PIPE_CTRL_STATS_EN
  logic              stall_inc, flush_inc;
  logic [STAT_W-1:0] stall_q, flush_q;

  assign stall_inc = !ex_branch_taken && (state != DISCARD) && hazard;
  assign flush_inc = ex_branch_taken;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + STAT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + STAT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_pipe_ctrl.md
# hazard_pipe_ctrl

Pipeline sequencing controller for the five-stage CPU. It drives the write-enable and flush controls of the PC and the IF/ID pipeline register, and the bubble-insert on ID/EX. It detects load-use and HI/LO hazards and sequences a multi-cycle multiply/divide unit. It also tracks instruction-memory wait states, including discarding a wrong-path fetch that returns after a taken branch.

## Interface
Parameters:
- MD_LATENCY, 32: cycles the mult/div unit stays busy after md_start (1..255)
- STAT_W, 32: width of statistics counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_is_md  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_memread  in  1  EX instruction is a load
- ex_rt  in  5  destination of EX load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- imem_ready  in  1  instruction memory data valid this cycle
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads all-zero NOP (wins over ifid_write)
- idex_bubble  out  1  ID/EX loads NOP control bits
- md_start  out  1  one-cycle start pulse to mult/div unit
- md_busy  out  1  mult/div unit occupied
- stall_cycles  out  STAT_W  hazard stall cycle count
- flush_count  out  STAT_W  taken-branch flush count

## Operation
- FSM states: RUN, IWAIT (fetch outstanding), DISCARD (outstanding fetch is wrong-path).
- Load-use hazard: ex_memread and ex_rt≠0 and ex_rt equals id_rs, or equals id_rt with id_uses_rt set.
- Per-cycle control, in priority order. Outputs not listed are 0.
  - 1. ex_branch_taken → pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, flush_count++.
    - From IWAIT with imem_ready=0: next state DISCARD.
    - From IWAIT with imem_ready=1: next state RUN.
  - 2. DISCARD state:
    - imem_ready=0 → pc_write=0, ifid_write=0, idex_bubble=0; stay in DISCARD.
    - imem_ready=1 → ifid_flush=1, pc_write=0. The returned word is dropped and the PC already holds the target. Next state RUN.
  - 3. Load-use hazard, or id_reads_hilo with md_busy, or id_is_md with md_busy → pc_write=0, ifid_write=0, idex_bubble=1, stall_cycles++.
  - 4. imem_ready=0 → pc_write=0, ifid_flush=1 (NOP into ID, downstream drains). Next state IWAIT.
  - 5. Otherwise → pc_write=1, ifid_write=1. Next state RUN.
- md_start=1 when id_is_md, md_busy=0, and no branch flush (priority 1) applies. It does not stall the ID instruction.
- Mult/div counter:
  - Loads MD_LATENCY on md_start and decrements to 0.
  - md_busy = (counter≠0).
- Statistics counters saturate at all-ones.

## Timing
- All controls are combinational from current state and inputs, valid within the same cycle; they are consumed at the next rising edge.
- State, mult/div counter and stats update on the rising edge.
- Load-use stall lasts exactly one cycle. The load leaves EX, so the hazard clears.
- After md_start at edge N, md_busy is high from N+1 through N+MD_LATENCY. A waiting mfhi/mflo proceeds in the following cycle.
- reset high, asynchronous:
  - State = RUN; mult/div counter = 0; stats = 0.
  - While reset is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, md_start=0, md_busy=0.
- Reset mid-divide aborts the busy count. Reset in DISCARD returns to RUN with no discard pending.

## Configuration
- PIPE_CTRL_STATS_EN defined: stall_cycles and flush_count are live counters as specified.
- PIPE_CTRL_STATS_EN undefined: the ports remain but are tied to 0, and no counter registers are built.

## Test plan
- Load-use: ex_memread=1, ex_rt=5, id_rs=5, imem_ready=1 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1, stall_cycles=1. Same stimulus with ex_rt=0 → no stall.
- Branch flush: ex_branch_taken=1 together with a load-use hazard → ifid_flush=1, idex_bubble=1, pc_write=1, flush_count=1, stall_cycles unchanged.
- Wrong-path discard: imem_ready=0 for 2 cycles, branch taken in the 2nd cycle, imem_ready=1 in the 4th cycle → state DISCARD, ifid_flush=1 and pc_write=0 in the 4th cycle, then RUN.
- Mult/div: MD_LATENCY=4, id_is_md=1 → md_start pulse, md_busy high 4 cycles. mfhi in ID → stalled 4 cycles, then passes. Back-to-back mult → stalled until idle.
- Async reset asserted mid-divide with stats nonzero → md_busy=0 and counters=0 immediately. After release, the first cycle with imem_ready=1 gives pc_write=1.
- Macro off: run the load-use and branch flush scenarios → stall_cycles and flush_count stay 0, while control behaviour is identical.
